chan_scan_mux: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with manual and auto-scan select modes. The successor to the combinational 4:1 mux: it adds a registered output, a dwell-timer-driven round-robin scan, a hold control and a select-change strobe. It sits between switch or sensor inputs and display or LED logic on the Basys 3 top level, clocked at 100 MHz.

---
 rtl/mux_pkg.sv | 13 +
 rtl/chan_scan_mux_dwell_timer.sv | 41 ++++
 rtl/chan_scan_mux.sv | 78 +++++++
 tb/tb_chan_scan_mux.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the mux family: select-mode encodings and a width
// helper that never returns zero.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

  // $clog2 gives 0 for n <= 1, which would make a zero-width vector.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chan_scan_mux_dwell_timer.sv
// Dwell counter for the auto-scan mux: counts 0..DWELL-1 while enabled and
// flags the last cycle of each dwell period.
module dwell_timer
  import mux_pkg::*;
#(
  parameter int DWELL = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int                CNT_W   = clog2_min1(DWELL);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc = en && (cnt_q == CNT_MAX);

  // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || tc) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/chan_scan_mux.sv
// N-channel registered mux with manual select, dwell-timed round-robin scan,
// a hold control and a one-cycle select-change strobe.
module chan_scan_mux
  import mux_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int WIDTH    = 1,
  parameter  int DWELL    = 50_000_000,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      hold,
  output logic [WIDTH-1:0]          y,
  output logic [SEL_W-1:0]          sel_out,
  output logic                      sel_change
);

  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(CHANNELS - 1);

  logic             mode_q;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] y_q;
  logic             sel_change_q;
  logic             mode_changed;
  logic             timer_en, timer_clr, timer_tc;

  assign mode_changed = (mode != mode_q);
  // A mode edge restarts the dwell so a fresh scan gets a full period.
  assign timer_en     = !hold && (mode == MODE_AUTO) && !mode_changed;
  assign timer_clr    = !hold && ((mode == MODE_MANUAL) || mode_changed);

  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (timer_en),
    .clr   (timer_clr),
    .tc    (timer_tc)
  );

  always_comb begin
    sel_d = sel_q;
    if (!hold) begin
      if (mode == MODE_MANUAL) begin
        // Out-of-range codes are ignored so sel never holds a missing channel.
        if (32'(sel_in) < CHANNELS) begin
          sel_d = sel_in;
        end
      end else if (timer_tc) begin
        sel_d = (sel_q == SEL_MAX) ? '0 : sel_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= MODE_MANUAL;
      sel_q        <= '0;
      y_q          <= '0;
      sel_change_q <= 1'b0;
    end else begin
      mode_q       <= mode;
      sel_q        <= sel_d;
      y_q          <= din[int'(sel_q)*WIDTH +: WIDTH];
      sel_change_q <= (sel_d != sel_q);
    end
  end

  assign y          = y_q;
  assign sel_out    = sel_q;
  assign sel_change = sel_change_q;

endmodule

// File: tb/tb_chan_scan_mux.sv
// Directed scenarios plus a randomized run against a countdown-based
// reference model of the scan mux.
module tb_chan_scan_mux;

  localparam int CHANNELS = 4;
  localparam int WIDTH    = 8;
  localparam int DWELL    = 3;
  localparam logic [31:0] DIN_BASE = 32'hDDCC_BBAA;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [CHANNELS*WIDTH-1:0] din = DIN_BASE;
  logic                      mode = 1'b0;
  logic [1:0]                sel_in = 2'd0;
  logic                      hold = 1'b0;
  logic [WIDTH-1:0]          y;
  logic [1:0]                sel_out;
  logic                      sel_change;

  int n_checks = 0;
  int n_fails  = 0;

  chan_scan_mux #(
    .CHANNELS (CHANNELS),
    .WIDTH    (WIDTH),
    .DWELL    (DWELL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .mode       (mode),
    .sel_in     (sel_in),
    .hold       (hold),
    .y          (y),
    .sel_out    (sel_out),
    .sel_change (sel_change)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] base_ch(input int k);
    return DIN_BASE[k*8 +: 8];
  endfunction

  // Reference model: m_left counts cycles remaining on the current channel.
  logic [1:0] m_sel;
  logic [7:0] m_y;
  logic       m_chg;
  logic       m_prev_mode;
  int         m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sel       <= 2'd0;
      m_y         <= 8'd0;
      m_chg       <= 1'b0;
      m_prev_mode <= 1'b0;
      m_left      <= DWELL;
    end else begin
      int nsel;
      int nleft;
      nsel  = int'(m_sel);
      nleft = m_left;
      if (!hold) begin
        if (mode != m_prev_mode) nleft = DWELL;
        if (mode == 1'b0) begin
          if (int'(sel_in) < CHANNELS) nsel = int'(sel_in);
          nleft = DWELL;
        end else if (mode == m_prev_mode) begin
          nleft = m_left - 1;
          if (nleft == 0) begin
            nsel  = (int'(m_sel) + 1) % CHANNELS;
            nleft = DWELL;
          end
        end
      end
      m_y         <= din[int'(m_sel)*WIDTH +: WIDTH];
      m_chg       <= (nsel != int'(m_sel));
      m_sel       <= 2'(nsel);
      m_prev_mode <= mode;
      m_left      <= nleft;
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    sel_in = 2'd2;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (y !== 8'h00) begin n_fails++; $display("FAIL reset_y: got %0h expected 00", y); end
    n_checks++; if (sel_out !== 2'd0) begin n_fails++; $display("FAIL reset_sel: got %0d expected 0", sel_out); end
    n_checks++; if (sel_change !== 1'b0) begin n_fails++; $display("FAIL reset_chg: got %0b expected 0", sel_change); end
    sel_in = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (y !== 8'hAA) begin n_fails++; $display("FAIL release_y: got %0h expected aa", y); end
    n_checks++; if (sel_change !== 1'b0) begin n_fails++; $display("FAIL release_chg: got %0b expected 0", sel_change); end
  endtask

  task automatic test_manual();
    sel_in = 2'd2;
    @(negedge clk);
    n_checks++; if (sel_out !== 2'd2) begin n_fails++; $display("FAIL man_sel: got %0d expected 2", sel_out); end
    n_checks++; if (sel_change !== 1'b1) begin n_fails++; $display("FAIL man_pulse: got %0b expected 1", sel_change); end
    n_checks++; if (y !== 8'hAA) begin n_fails++; $display("FAIL man_y_lag: got %0h expected aa", y); end
    @(negedge clk);
    n_checks++; if (y !== 8'hCC) begin n_fails++; $display("FAIL man_y: got %0h expected cc", y); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (sel_change !== 1'b0) begin n_fails++; $display("FAIL man_no_pulse[%0d]: got %0b expected 0", i, sel_change); end
      @(negedge clk);
    end
  endtask

  task automatic test_auto_scan();
    int pulses;
    logic [1:0] exp_sel;
    logic [7:0] exp_y;
    logic       exp_chg;
    sel_in = 2'd0;
    repeat (2) @(negedge clk);
    mode   = 1'b1;
    pulses = 0;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      exp_sel = 2'((k / DWELL) % CHANNELS);
      exp_chg = (k > 0) && (k % DWELL == 0);
      exp_y   = base_ch(((k == 0) ? 0 : (k - 1) / DWELL) % CHANNELS);
      if (sel_change === 1'b1) pulses++;
      n_checks++; if (sel_out !== exp_sel) begin n_fails++; $display("FAIL scan_sel[%0d]: got %0d expected %0d", k, sel_out, exp_sel); end
      n_checks++; if (sel_change !== exp_chg) begin n_fails++; $display("FAIL scan_chg[%0d]: got %0b expected %0b", k, sel_change, exp_chg); end
      n_checks++; if (y !== exp_y) begin n_fails++; $display("FAIL scan_y[%0d]: got %0h expected %0h", k, y, exp_y); end
    end
    n_checks++; if (pulses != 4) begin n_fails++; $display("FAIL scan_pulses: got %0d expected 4", pulses); end
  endtask

  task automatic test_hold();
    repeat (3) @(negedge clk);
    n_checks++; if (sel_out !== 2'd1) begin n_fails++; $display("FAIL hold_pre_sel: got %0d expected 1", sel_out); end
    @(negedge clk);
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++; if (sel_out !== 2'd1 || sel_change !== 1'b0) begin
        n_fails++; $display("FAIL hold_freeze[%0d]: got sel %0d chg %0b expected sel 1 chg 0", i, sel_out, sel_change);
      end
    end
    n_checks++; if (y !== 8'hBB) begin n_fails++; $display("FAIL hold_y: got %0h expected bb", y); end
    hold = 1'b0;
    @(negedge clk);
    n_checks++; if (sel_out !== 2'd1) begin n_fails++; $display("FAIL hold_resume1: got %0d expected 1", sel_out); end
    @(negedge clk);
    n_checks++; if (sel_out !== 2'd2 || sel_change !== 1'b1) begin
      n_fails++; $display("FAIL hold_resume2: got sel %0d chg %0b expected sel 2 chg 1", sel_out, sel_change);
    end
  endtask

  task automatic test_mode_switch();
    repeat (3) @(negedge clk);
    n_checks++; if (sel_out !== 2'd3) begin n_fails++; $display("FAIL sw_on_ch3: got %0d expected 3", sel_out); end
    mode   = 1'b0;
    sel_in = 2'd1;
    @(negedge clk);
    n_checks++; if (sel_out !== 2'd1 || sel_change !== 1'b1) begin
      n_fails++; $display("FAIL sw_to_manual: got sel %0d chg %0b expected sel 1 chg 1", sel_out, sel_change);
    end
    @(negedge clk);
    mode = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      n_checks++; if (sel_out !== ((j == 3) ? 2'd2 : 2'd1)) begin
        n_fails++; $display("FAIL sw_to_auto[%0d]: got %0d expected %0d", j, sel_out, (j == 3) ? 2 : 1);
      end
    end
  endtask

  task automatic test_live_data();
    mode   = 1'b0;
    sel_in = 2'd0;
    repeat (2) @(negedge clk);
    din[7:0] = 8'h5A;
    @(negedge clk);
    n_checks++; if (y !== 8'h5A) begin n_fails++; $display("FAIL live_y: got %0h expected 5a", y); end
    n_checks++; if (sel_change !== 1'b0) begin n_fails++; $display("FAIL live_chg: got %0b expected 0", sel_change); end
    din = DIN_BASE;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      n_checks++; if (sel_out !== m_sel) begin n_fails++; $display("FAIL rnd_sel[%0d]: got %0d expected %0d", i, sel_out, m_sel); end
      n_checks++; if (y !== m_y) begin n_fails++; $display("FAIL rnd_y[%0d]: got %0h expected %0h", i, y, m_y); end
      n_checks++; if (sel_change !== m_chg) begin n_fails++; $display("FAIL rnd_chg[%0d]: got %0b expected %0b", i, sel_change, m_chg); end
      rst_n = (i == 300) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      hold = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) sel_in = 2'($urandom_range(0, 3));
      din = $urandom;
    end
    rst_n = 1'b1;
    hold  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_manual();
    test_auto_scan();
    test_hold();
    test_mode_switch();
    test_live_data();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
